mouse_cmd_scheduler: RTL and testbench

Arbitrates command bytes from several host-side requesters (init sequencer, sample-rate/resolution config, user debug port) onto the single PS/2 mouse transmitter. It sequences each command through send, acknowledge wait and retry, and sits between the requesters and the transmitter/receiver pair inside the mouse transceiver. While it owns the receiver it consumes the mouse's response byte, so stream packets never reach requesters as command responses.

---
 rtl/mouse_cmd_pkg.sv | 19 +
 rtl/mouse_cmd_scheduler_rr_arbiter.sv | 32 +++
 rtl/mouse_cmd_scheduler.sv | 148 ++++++++++++++
 tb/tb_mouse_cmd_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_cmd_pkg.sv
// Shared types and PS/2 command/response codes for the mouse command scheduler.
package mouse_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_SENT,
      WAIT_ACK,
      FINISH
   } cmdStateT;

   localparam logic [7:0] PS2_ACK      = 8'hFA;
   localparam logic [7:0] PS2_RESEND   = 8'hFE;
   localparam logic [7:0] PS2_ERROR    = 8'hFC;
   localparam logic [7:0] PS2_RESET    = 8'hFF;
   localparam logic [7:0] PS2_SET_RATE = 8'hF3;
   localparam logic [7:0] PS2_ENABLE   = 8'hF4;

endpackage

// File: rtl/mouse_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IW-1:0]      pickIdx,
   output logic               anyReq
);

   always_comb begin : pickScan
      int unsigned cand;
      cand    = 0;
      pick    = '0;
      pickIdx = '0;
      anyReq  = 1'b0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         cand = 32'(ptr) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!anyReq && req[IW'(cand)]) begin
            anyReq             = 1'b1;
            pick[IW'(cand)]    = 1'b1;
            pickIdx            = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/mouse_cmd_scheduler.sv
// Arbitrates requester command bytes onto the PS/2 transmitter and tracks ACK/resend/error.
module mouse_cmd_scheduler
   import mouse_cmd_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned ACK_TIMEOUT = 1_000_000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [NUM_REQ-1:0]   REQ,
   input  logic [8*NUM_REQ-1:0] REQ_BYTE,
   output logic [NUM_REQ-1:0]   GRANT,
   output logic [NUM_REQ-1:0]   DONE,
   output logic [NUM_REQ-1:0]   ERR,
   output logic [7:0]           RESP_BYTE,
   output logic                 BUSY,
   output logic                 SEND_BYTE,
   output logic [7:0]           BYTE_TO_SEND,
   input  logic                 BYTE_SENT,
   output logic                 READ_ENABLE,
   input  logic                 BYTE_READY,
   input  logic [7:0]           BYTE_READ,
   input  logic [1:0]           BYTE_ERROR_CODE
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   cmdStateT             state;
   logic [IW-1:0]        rrPtr;
   logic [IW-1:0]        idx;
   logic [RW-1:0]        retryCnt;
   logic [TW-1:0]        timer;

   logic [NUM_REQ-1:0]   pick;
   logic [IW-1:0]        pickIdx;
   logic                 anyReq;
   logic [7:0]           pickByte;
   logic [IW-1:0]        nextPtr;
   logic                 timeout;
   logic                 ackBad;
   logic                 canRetry;
   logic                 retryReq;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
      .req     (REQ),
      .ptr     (rrPtr),
      .pick    (pick),
      .pickIdx (pickIdx),
      .anyReq  (anyReq)
   );

   assign pickByte = REQ_BYTE[{pickIdx, 3'b000} +: 8];
   assign nextPtr  = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
   assign timeout  = (timer == TW'(ACK_TIMEOUT));
   assign ackBad   = (BYTE_ERROR_CODE != 2'b00) || (BYTE_READ == PS2_RESEND);
   assign canRetry = (retryCnt < RW'(MAX_RETRY));
   // A byte on BYTE_READY outranks a simultaneous timeout.
   assign retryReq = BYTE_READY ? ackBad : timeout;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         rrPtr        <= '0;
         idx          <= '0;
         retryCnt     <= '0;
         timer        <= '0;
         GRANT        <= '0;
         DONE         <= '0;
         ERR          <= '0;
         RESP_BYTE    <= 8'h00;
         BUSY         <= 1'b0;
         SEND_BYTE    <= 1'b0;
         BYTE_TO_SEND <= 8'h00;
         READ_ENABLE  <= 1'b0;
      end else begin
         DONE <= '0;
         ERR  <= '0;
         case (state)
            IDLE: begin
               if (anyReq) begin
                  idx          <= pickIdx;
                  GRANT        <= pick;
                  BYTE_TO_SEND <= pickByte;
                  RESP_BYTE    <= 8'h00;
                  retryCnt     <= '0;
                  BUSY         <= 1'b1;
                  SEND_BYTE    <= 1'b1;
                  state        <= SEND;
               end
            end
            SEND: begin
               SEND_BYTE <= 1'b0;
               timer     <= '0;
               state     <= WAIT_SENT;
            end
            WAIT_SENT: begin
               if (BYTE_SENT) begin
                  timer       <= '0;
                  READ_ENABLE <= 1'b1;
                  state       <= WAIT_ACK;
               end else if (timeout) begin
                  ERR   <= GRANT;
                  state <= FINISH;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            WAIT_ACK: begin
               if (BYTE_READY) begin
                  RESP_BYTE <= BYTE_READ;
               end
               if (retryReq) begin
                  READ_ENABLE <= 1'b0;
                  if (canRetry) begin
                     retryCnt  <= retryCnt + RW'(1);
                     SEND_BYTE <= 1'b1;
                     state     <= SEND;
                  end else begin
                     ERR   <= GRANT;
                     state <= FINISH;
                  end
               end else if (BYTE_READY && (BYTE_READ == PS2_ACK)) begin
                  READ_ENABLE <= 1'b0;
                  DONE        <= GRANT;
                  state       <= FINISH;
               end else if (BYTE_READY && (BYTE_READ == PS2_ERROR)) begin
                  READ_ENABLE <= 1'b0;
                  ERR         <= GRANT;
                  state       <= FINISH;
               end else if (!timeout) begin
                  timer <= timer + TW'(1);
               end
            end
            FINISH: begin
               GRANT <= '0;
               BUSY  <= 1'b0;
               rrPtr <= nextPtr;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mouse_cmd_scheduler.sv
// Directed bench for mouse_cmd_scheduler: vector table plus scripted retry/timeout/reset sequences.
module tb_mouse_cmd_scheduler;

   localparam int unsigned NREQ     = 2;
   localparam int unsigned ACK_T    = 120;
   localparam int unsigned SENT_DLY = 2;

   logic            CLK;
   logic            RESET;
   logic [1:0]      REQ;
   logic [15:0]     REQ_BYTE;
   logic [1:0]      GRANT, DONE, ERR;
   logic [7:0]      RESP_BYTE, BYTE_TO_SEND, BYTE_READ;
   logic            BUSY, SEND_BYTE, BYTE_SENT, READ_ENABLE, BYTE_READY;
   logic [1:0]      BYTE_ERROR_CODE;

   mouse_cmd_scheduler #(.NUM_REQ(NREQ), .ACK_TIMEOUT(ACK_T), .MAX_RETRY(3)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_BYTE(REQ_BYTE),
      .GRANT(GRANT), .DONE(DONE), .ERR(ERR), .RESP_BYTE(RESP_BYTE), .BUSY(BUSY),
      .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
      .READ_ENABLE(READ_ENABLE), .BYTE_READY(BYTE_READY), .BYTE_READ(BYTE_READ),
      .BYTE_ERROR_CODE(BYTE_ERROR_CODE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0] req;
      int         sentDly;
      logic [7:0] reply;
      logic [1:0] ec;
      logic [1:0] expGrant;
      logic [1:0] expDone;
      logic [1:0] expErr;
      logic [7:0] expResp;
   } vecT;

   typedef struct {
      bit         awaitSend;
      bit         sent;
      int         sentDelay;
      bit         reply;
      logic [7:0] b;
      logic [1:0] ec;
   } stepT;

   vecT        vecs [6];
   stepT       script [$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         sendTimes [$];
   int         badByte = 0;
   int         pulseCycles = 0;
   bit         outcomeSeen = 0;
   logic [1:0] outDone, outErr, outGrant;
   logic [7:0] outResp;
   logic       outBusy;
   int         outTime = 0;
   int         readyTime = 0;
   int         reqTime = 0;
   logic [7:0] expByte = 8'h00;
   logic [1:0] nextReq = 2'b00;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic boundFail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
   endtask

   // One cycle: advance to the falling edge and record DUT activity.
   task automatic tick();
      @(negedge CLK);
      cyc++;
      if (SEND_BYTE) begin
         sendTimes.push_back(cyc);
         if (BYTE_TO_SEND !== expByte) badByte++;
      end
      if ((|DONE) || (|ERR)) begin
         pulseCycles++;
         if (!outcomeSeen) begin
            outcomeSeen = 1;
            outDone  = DONE;
            outErr   = ERR;
            outResp  = RESP_BYTE;
            outGrant = GRANT;
            outBusy  = BUSY;
            outTime  = cyc;
         end
      end
   endtask

   task automatic clrTxn();
      sendTimes.delete();
      badByte     = 0;
      pulseCycles = 0;
      outcomeSeen = 0;
   endtask

   task automatic pushStep(input bit aw, input bit snt, input int dly, input bit rep,
                           input logic [7:0] b, input logic [1:0] ec);
      stepT s;
      s.awaitSend = aw;
      s.sent      = snt;
      s.sentDelay = dly;
      s.reply     = rep;
      s.b         = b;
      s.ec        = ec;
      script.push_back(s);
   endtask

   // Plays transmitter/receiver per the script; optionally waits for DONE/ERR.
   task automatic runScript(input bit waitOut);
      stepT s;
      int   g;
      while (script.size() > 0) begin
         s = script.pop_front();
         if (s.awaitSend) begin
            g = 0;
            while (!SEND_BYTE && g < 500) begin tick(); g++; end
            if (!SEND_BYTE) boundFail("await_send");
            if (s.sent) begin
               repeat (s.sentDelay) tick();
               BYTE_SENT = 1'b1;
               tick();
               BYTE_SENT = 1'b0;
            end
         end
         if (s.reply) begin
            g = 0;
            while (!READ_ENABLE && g < 500) begin tick(); g++; end
            if (!READ_ENABLE) boundFail("await_read_enable");
            repeat (2) tick();
            BYTE_READ       = s.b;
            BYTE_ERROR_CODE = s.ec;
            BYTE_READY      = 1'b1;
            readyTime       = cyc;
            tick();
            BYTE_READY      = 1'b0;
            BYTE_ERROR_CODE = 2'b00;
         end
      end
      if (waitOut) begin
         g = 0;
         while (!outcomeSeen && g < 1000) begin tick(); g++; end
         if (!outcomeSeen) boundFail("await_outcome");
         REQ = nextReq;
      end
   endtask

   task automatic finishTxn(input string nm, input logic [1:0] eg, input logic [1:0] ed,
                            input logic [1:0] ee, input logic [7:0] er, input int es);
      chk({nm, "_grant"}, 32'(outGrant), 32'(eg));
      chk({nm, "_done"}, 32'(outDone), 32'(ed));
      chk({nm, "_err"}, 32'(outErr), 32'(ee));
      chk({nm, "_resp"}, 32'(outResp), 32'(er));
      chk({nm, "_sends"}, 32'(sendTimes.size()), 32'(es));
      chk({nm, "_sendbyte"}, 32'(badByte), 32'd0);
      chk({nm, "_busy_fin"}, 32'(outBusy), 32'd1);
      tick();
      chk({nm, "_pulsewidth"}, 32'(pulseCycles), 32'd1);
      chk({nm, "_busy_idle"}, 32'(BUSY), 32'd0);
      clrTxn();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int lat;
      int spacing;

      vecs[0] = '{2'b01, 100,      8'hFA, 2'b00, 2'b01, 2'b01, 2'b00, 8'hFA};
      vecs[1] = '{2'b11, SENT_DLY, 8'hFA, 2'b00, 2'b10, 2'b10, 2'b00, 8'hFA};
      vecs[2] = '{2'b11, SENT_DLY, 8'hFA, 2'b00, 2'b01, 2'b01, 2'b00, 8'hFA};
      vecs[3] = '{2'b11, SENT_DLY, 8'hFA, 2'b00, 2'b10, 2'b10, 2'b00, 8'hFA};
      vecs[4] = '{2'b01, SENT_DLY, 8'hFC, 2'b00, 2'b01, 2'b00, 2'b01, 8'hFC};
      vecs[5] = '{2'b10, SENT_DLY, 8'hFA, 2'b00, 2'b10, 2'b10, 2'b00, 8'hFA};

      RESET           = 1'b1;
      REQ             = 2'b00;
      REQ_BYTE        = {8'hF3, 8'hF4};
      BYTE_SENT       = 1'b0;
      BYTE_READY      = 1'b0;
      BYTE_READ       = 8'h00;
      BYTE_ERROR_CODE = 2'b00;
      repeat (3) tick();

      chk("rst_grant", 32'(GRANT), 32'd0);
      chk("rst_done_err", 32'({DONE, ERR}), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_send", 32'(SEND_BYTE), 32'd0);
      chk("rst_read_en", 32'(READ_ENABLE), 32'd0);
      chk("rst_bytes", 32'({RESP_BYTE, BYTE_TO_SEND}), 32'd0);
      RESET = 1'b0;
      tick();
      clrTxn();

      // Single-byte transactions, REQ for the next row presented in the FINISH cycle.
      for (int r = 0; r < 6; r++) begin
         expByte = vecs[r].expGrant[1] ? 8'hF3 : 8'hF4;
         if (r == 0) begin
            REQ     = vecs[0].req;
            reqTime = cyc;
         end else begin
            reqTime = outTime;
         end
         nextReq = (r < 5) ? vecs[r+1].req : 2'b00;
         pushStep(1, 1, vecs[r].sentDly, 1, vecs[r].reply, vecs[r].ec);
         runScript(1);
         lat = (sendTimes.size() > 0) ? sendTimes[0] - reqTime : -1;
         chk($sformatf("vec%0d_grant_lat", r), 32'(lat), (r == 0) ? 32'd1 : 32'd2);
         chk($sformatf("vec%0d_done_lat", r), 32'(outTime - readyTime), 32'd1);
         finishTxn($sformatf("vec%0d", r), vecs[r].expGrant, vecs[r].expDone,
                   vecs[r].expErr, vecs[r].expResp, 1);
      end

      // Resend twice, then ACK.
      expByte = 8'hF4;
      REQ     = 2'b01;
      nextReq = 2'b00;
      pushStep(1, 1, SENT_DLY, 1, 8'hFE, 2'b00);
      pushStep(1, 1, SENT_DLY, 1, 8'hFE, 2'b00);
      pushStep(1, 1, SENT_DLY, 1, 8'hFA, 2'b00);
      runScript(1);
      finishTxn("resend", 2'b01, 2'b01, 2'b00, 8'hFA, 3);

      // Resend every time: retries exhausted.
      expByte = 8'hF3;
      REQ     = 2'b10;
      for (int i = 0; i < 4; i++) pushStep(1, 1, SENT_DLY, 1, 8'hFE, 2'b00);
      runScript(1);
      finishTxn("exhaust_fe", 2'b10, 2'b00, 2'b10, 8'hFE, 4);

      // Noise byte ignored, parity error retried, then ACK.
      expByte = 8'hF4;
      REQ     = 2'b01;
      pushStep(1, 1, SENT_DLY, 1, 8'h08, 2'b00);
      pushStep(0, 0, 0,        1, 8'hFA, 2'b01);
      pushStep(1, 1, SENT_DLY, 1, 8'hFA, 2'b00);
      runScript(1);
      finishTxn("noise_parity", 2'b01, 2'b01, 2'b00, 8'hFA, 2);

      // No response at all: four sends spaced by the ACK timeout.
      expByte = 8'hF3;
      REQ     = 2'b10;
      for (int i = 0; i < 4; i++) pushStep(1, 1, SENT_DLY, 0, 8'h00, 2'b00);
      runScript(1);
      spacing = SENT_DLY + 2 + ACK_T;
      chk("ack_to_space1", 32'((sendTimes.size() > 1) ? sendTimes[1] - sendTimes[0] : -1), 32'(spacing));
      chk("ack_to_space3", 32'((sendTimes.size() > 3) ? sendTimes[3] - sendTimes[2] : -1), 32'(spacing));
      chk("ack_to_err", 32'((sendTimes.size() > 3) ? outTime - sendTimes[3] : -1), 32'(spacing));
      finishTxn("ack_timeout", 2'b10, 2'b00, 2'b10, 8'h00, 4);

      // Transmitter hang: one send, error after WAIT_SENT timeout.
      expByte = 8'hF4;
      REQ     = 2'b01;
      pushStep(1, 0, 0, 0, 8'h00, 2'b00);
      runScript(1);
      chk("sent_to_err", 32'((sendTimes.size() > 0) ? outTime - sendTimes[0] : -1), 32'(2 + ACK_T));
      finishTxn("sent_timeout", 2'b01, 2'b00, 2'b01, 8'h00, 1);

      // Reset while waiting for the ACK.
      expByte = 8'hF4;
      REQ     = 2'b01;
      pushStep(1, 1, SENT_DLY, 0, 8'h00, 2'b00);
      runScript(0);
      repeat (3) tick();
      chk("mid_read_en", 32'(READ_ENABLE), 32'd1);
      RESET = 1'b1;
      tick();
      chk("mid_rst_grant", 32'(GRANT), 32'd0);
      chk("mid_rst_busy", 32'(BUSY), 32'd0);
      chk("mid_rst_send", 32'(SEND_BYTE), 32'd0);
      chk("mid_rst_read_en", 32'(READ_ENABLE), 32'd0);
      chk("mid_rst_bytes", 32'({RESP_BYTE, BYTE_TO_SEND}), 32'd0);
      chk("mid_rst_nopulse", 32'(outcomeSeen), 32'd0);
      REQ     = 2'b10;
      RESET   = 1'b0;
      clrTxn();
      expByte = 8'hF3;
      reqTime = cyc;
      pushStep(1, 1, SENT_DLY, 1, 8'hFA, 2'b00);
      runScript(1);
      chk("post_rst_grant_lat", 32'((sendTimes.size() > 0) ? sendTimes[0] - reqTime : -1), 32'd1);
      finishTxn("post_rst", 2'b10, 2'b10, 2'b00, 8'hFA, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
